// File: rtl/cosim_pkg.sv
// cosim_pkg: shared types for commit-log records exchanged with the Spike co-simulation checker
package cosim_pkg;
  localparam int CommitLogEntries = 16;
  typedef logic [63:0] reg_t;
  typedef logic [63:0] freg_t;
  typedef enum logic [1:0] {XREG, FREG, VREG, CSR} reg_key_type_e;
  typedef struct packed {
    logic [11:0]   id;
    reg_key_type_e key_type;
  } reg_key_t;
  typedef struct packed {
    reg_key_t key;
    freg_t    value;
  } commit_log_reg_item_t;
endpackage

// File: rtl/cosim_commit_logger_if.sv
// cosim_commit_logger_if: retirement inputs and record handshake of the commit logger
interface cosim_commit_logger_if #(
  parameter int CommitLogEntries = cosim_pkg::CommitLogEntries,
  parameter int FifoDepth = 4
);
  import cosim_pkg::*;
  localparam int CW = $clog2(CommitLogEntries + 1);
  localparam int LW = $clog2(FifoDepth + 1);
  logic                 reg_wr_valid_i;
  reg_key_t             reg_wr_key_i;
  freg_t                reg_wr_value_i;
  logic                 retire_valid_i;
  reg_t                 retire_pc_i;
  logic                 rec_valid_o;
  logic                 rec_ready_i;
  reg_t                 rec_pc_o;
  commit_log_reg_item_t rec_reg_write_o [CommitLogEntries];
  logic [CW-1:0]        rec_count_o;
  logic [LW-1:0]        level_o;
  logic                 overflow_o;
  logic                 drop_o;
  modport master (
    output reg_wr_valid_i, reg_wr_key_i, reg_wr_value_i, retire_valid_i, retire_pc_i, rec_ready_i,
    input  rec_valid_o, rec_pc_o, rec_reg_write_o, rec_count_o, level_o, overflow_o, drop_o
  );
  modport slave (
    input  reg_wr_valid_i, reg_wr_key_i, reg_wr_value_i, retire_valid_i, retire_pc_i, rec_ready_i,
    output rec_valid_o, rec_pc_o, rec_reg_write_o, rec_count_o, level_o, overflow_o, drop_o
  );
endinterface

// File: rtl/cosim_commit_logger.sv
// cosim_commit_logger: accumulates per-instruction register writes and queues pc+writes records at retire
module cosim_commit_logger #(
  parameter int CommitLogEntries = cosim_pkg::CommitLogEntries,
  parameter int FifoDepth = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cosim_commit_logger_if.slave bus
);
  import cosim_pkg::*;
  localparam int CW = $clog2(CommitLogEntries + 1);
  localparam int IW = $clog2(CommitLogEntries);
  localparam int LW = $clog2(FifoDepth + 1);
  localparam int PW = $clog2(FifoDepth);
  logic [CW-1:0]        acc_cnt, new_cnt;
  commit_log_reg_item_t acc [CommitLogEntries];
  commit_log_reg_item_t new_rec [CommitLogEntries];
  commit_log_reg_item_t wr_item;
  logic                 room, push, pop, overflow, drop;
  logic [PW-1:0]        head, tail;
  logic [LW-1:0]        level;
  reg_t                 mem_pc [FifoDepth];
  logic [CW-1:0]        mem_cnt [FifoDepth];
  commit_log_reg_item_t mem_wr [FifoDepth][CommitLogEntries];
  assign wr_item = '{key: bus.reg_wr_key_i, value: bus.reg_wr_value_i};
  assign room = acc_cnt != CW'(CommitLogEntries);
  assign pop = (level != '0) && bus.rec_ready_i;
  assign push = bus.retire_valid_i && (level != LW'(FifoDepth) || pop);
  assign new_cnt = acc_cnt + CW'(bus.reg_wr_valid_i && room);
  // Same-cycle write lands in the slot right after the accumulated ones; stale slots read as zero
  always_comb
    for (int i = 0; i < CommitLogEntries; i++)
      new_rec[i] = (CW'(i) < acc_cnt) ? acc[i] :
                   (CW'(i) == acc_cnt && bus.reg_wr_valid_i) ? wr_item : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      acc_cnt  <= '0;
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop     <= 1'b0;
    end else begin
      acc_cnt  <= bus.retire_valid_i ? '0 : new_cnt;
      overflow <= overflow | (bus.reg_wr_valid_i && !room);
      drop     <= drop | (bus.retire_valid_i && !push);
      tail     <= tail + PW'(push);
      head     <= head + PW'(pop);
      level    <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk_i) begin
    if (bus.reg_wr_valid_i && room) acc[acc_cnt[IW-1:0]] <= wr_item;
    if (push) begin
      mem_pc[tail]  <= bus.retire_pc_i;
      mem_cnt[tail] <= new_cnt;
      for (int i = 0; i < CommitLogEntries; i++) mem_wr[tail][i] <= new_rec[i];
    end
  end
  // Head is read straight from storage and forced to zero when empty so reset leaves clean outputs
  assign bus.rec_valid_o = level != '0;
  assign bus.rec_pc_o    = bus.rec_valid_o ? mem_pc[head] : '0;
  assign bus.rec_count_o = bus.rec_valid_o ? mem_cnt[head] : '0;
  assign bus.level_o     = level;
  assign bus.overflow_o  = overflow;
  assign bus.drop_o      = drop;
  always_comb
    for (int i = 0; i < CommitLogEntries; i++)
      bus.rec_reg_write_o[i] = bus.rec_valid_o ? mem_wr[head][i] : '0;
endmodule

// File: tb/tb_cosim_commit_logger.sv
// tb_cosim_commit_logger: directed and randomized checks of the commit logger against a queue-based model
module tb_cosim_commit_logger;
  import cosim_pkg::*;
  localparam int CE = 16;
  localparam int FD = 4;
  typedef struct {
    reg_t pc;
    int   cnt;
    commit_log_reg_item_t w [CE];
  } rec_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int tests = 0;
  int fails = 0;
  rec_t mq [$];
  commit_log_reg_item_t accq [$];
  bit m_ovf = 0;
  bit m_drop = 0;
  cosim_commit_logger_if #(.CommitLogEntries(CE), .FifoDepth(FD)) bus ();
  cosim_commit_logger #(.CommitLogEntries(CE), .FifoDepth(FD)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus.slave)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic commit_log_reg_item_t item(input int id, input reg_key_type_e t, input freg_t v);
    item = '{key: '{id: 12'(id), key_type: t}, value: v};
  endfunction
  // Reference model: a queue of whole records plus a queue of pending writes
  always @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mq.delete();
      accq.delete();
      m_ovf = 0;
      m_drop = 0;
    end else begin
      bit pop, full;
      rec_t r;
      pop = mq.size() != 0 && bus.rec_ready_i;
      full = mq.size() == FD;
      if (bus.reg_wr_valid_i) begin
        if (accq.size() < CE) accq.push_back(item(int'(bus.reg_wr_key_i.id), bus.reg_wr_key_i.key_type, bus.reg_wr_value_i));
        else m_ovf = 1;
      end
      if (pop) void'(mq.pop_front());
      if (bus.retire_valid_i) begin
        r.pc = bus.retire_pc_i;
        r.cnt = accq.size();
        for (int i = 0; i < CE; i++) r.w[i] = (i < accq.size()) ? accq[i] : '0;
        if (!full || pop) mq.push_back(r);
        else m_drop = 1;
        accq.delete();
      end
    end
  always @(negedge clk_i) begin
    rec_t e;
    e.pc = '0;
    e.cnt = 0;
    for (int i = 0; i < CE; i++) e.w[i] = '0;
    if (mq.size() != 0) e = mq[0];
    chk("valid", bus.rec_valid_o, mq.size() != 0);
    chk("level", bus.level_o, mq.size());
    chk("overflow", bus.overflow_o, m_ovf);
    chk("drop", bus.drop_o, m_drop);
    chk("pc", bus.rec_pc_o, e.pc);
    chk("count", bus.rec_count_o, e.cnt);
    for (int i = 0; i < CE; i++) chk($sformatf("entry%0d", i), bus.rec_reg_write_o[i], e.w[i]);
  end
  task automatic idle();
    bus.reg_wr_valid_i = 0;
    bus.reg_wr_key_i = '0;
    bus.reg_wr_value_i = '0;
    bus.retire_valid_i = 0;
    bus.retire_pc_i = '0;
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input int id, input reg_key_type_e t, input freg_t v);
    bus.reg_wr_valid_i = 1;
    bus.reg_wr_key_i = '{id: 12'(id), key_type: t};
    bus.reg_wr_value_i = v;
  endtask
  task automatic ret(input reg_t pc);
    bus.retire_valid_i = 1;
    bus.retire_pc_i = pc;
  endtask
  task automatic rand_inputs(input int wr_pct, input int ret_pct, input int rdy_pct);
    bus.reg_wr_valid_i = $urandom_range(0, 99) < wr_pct;
    bus.reg_wr_key_i = '{id: 12'($urandom), key_type: reg_key_type_e'($urandom_range(0, 3))};
    bus.reg_wr_value_i = {$urandom, $urandom};
    bus.retire_valid_i = $urandom_range(0, 99) < ret_pct;
    bus.retire_pc_i = {$urandom, $urandom};
    bus.rec_ready_i = $urandom_range(0, 99) < rdy_pct;
  endtask
  initial begin
    idle();
    bus.rec_ready_i = 0;
    for (int k = 0; k < 6; k++) begin
      rand_inputs(80, 80, 50);
      cyc();
    end
    chk("rst_valid", bus.rec_valid_o, 1'b0);
    chk("rst_count", bus.rec_count_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_overflow", bus.overflow_o, 1'b0);
    chk("rst_drop", bus.drop_o, 1'b0);
    idle();
    bus.rec_ready_i = 0;
    cyc();
    rst_i = 0;
    cyc();
    wr(5, XREG, 64'h1234);
    cyc();
    idle();
    ret(64'h8000_0000);
    cyc();
    idle();
    chk("t2_valid", bus.rec_valid_o, 1'b1);
    chk("t2_pc", bus.rec_pc_o, 64'h8000_0000);
    chk("t2_count", bus.rec_count_o, 1);
    chk("t2_entry0", bus.rec_reg_write_o[0], item(5, XREG, 64'h1234));
    chk("t2_entry1", bus.rec_reg_write_o[1], 0);
    bus.rec_ready_i = 1;
    cyc();
    bus.rec_ready_i = 0;
    chk("t2_empty", bus.rec_valid_o, 1'b0);
    wr(12'h300, CSR, 64'h8);
    ret(64'h8000_0004);
    cyc();
    idle();
    chk("t3_count", bus.rec_count_o, 1);
    chk("t3_entry0", bus.rec_reg_write_o[0], item(12'h300, CSR, 64'h8));
    ret(64'h8000_0008);
    bus.rec_ready_i = 1;
    cyc();
    idle();
    chk("t3_next_pc", bus.rec_pc_o, 64'h8000_0008);
    chk("t3_next_count", bus.rec_count_o, 0);
    cyc();
    bus.rec_ready_i = 0;
    for (int k = 1; k <= 17; k++) begin
      wr(k, XREG, 64'(k));
      cyc();
      if (k == 16) chk("t4_ovf_before", bus.overflow_o, 1'b0);
    end
    idle();
    chk("t4_ovf_after", bus.overflow_o, 1'b1);
    ret(64'h8000_0010);
    cyc();
    idle();
    chk("t4_count", bus.rec_count_o, 16);
    chk("t4_entry0", bus.rec_reg_write_o[0], item(1, XREG, 64'd1));
    chk("t4_entry15", bus.rec_reg_write_o[15], item(16, XREG, 64'd16));
    bus.rec_ready_i = 1;
    cyc();
    bus.rec_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      ret(64'h100 + 64'(4 * k));
      cyc();
    end
    chk("t6_full", bus.level_o, 4);
    ret(64'h200);
    bus.rec_ready_i = 1;
    cyc();
    idle();
    bus.rec_ready_i = 0;
    chk("t6_level", bus.level_o, 4);
    chk("t6_drop", bus.drop_o, 1'b0);
    bus.rec_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_order", bus.rec_pc_o, (k == 3) ? 64'h200 : 64'h104 + 64'(4 * k));
      cyc();
    end
    bus.rec_ready_i = 0;
    for (int k = 0; k < 5; k++) begin
      ret(64'(4 * k));
      cyc();
    end
    idle();
    chk("t5_level", bus.level_o, 4);
    chk("t5_drop", bus.drop_o, 1'b1);
    bus.rec_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_pop_pc", bus.rec_pc_o, 64'(4 * k));
      cyc();
    end
    chk("t5_empty", bus.rec_valid_o, 1'b0);
    rst_i = 1;
    cyc();
    rst_i = 0;
    for (int s = 0; s < 8; s++) begin
      int wp, rp, dp;
      wp = $urandom_range(30, 95);
      rp = (s % 3 == 0) ? 3 : $urandom_range(10, 60);
      dp = $urandom_range(5, 95);
      for (int k = 0; k < 400; k++) begin
        rand_inputs(wp, rp, dp);
        if (s == 4 && k == 200) rst_i = 1;
        if (s == 4 && k == 203) rst_i = 0;
        cyc();
      end
    end
    idle();
    bus.rec_ready_i = 1;
    repeat (FD + 2) cyc();
    chk("final_empty", bus.rec_valid_o, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cosim_commit_logger.md
# cosim_commit_logger

DUT-side producer of commit-log records for Spike co-simulation. It samples the core's retirement interface, accumulates every register write belonging to the in-flight instruction, and closes the record at retire. Records (pc plus up to `CommitLogEntries` `commit_log_reg_item_t` entries) are queued in a small FIFO. The testbench checker drains them through a valid/ready handshake and compares each one against the Spike log returned by `get_log_reg_write`/`get_pc` after each `step()`.

## Interface

Parameters:
- `CommitLogEntries`, default `cosim_pkg::CommitLogEntries` (16): maximum register writes kept per instruction.
- `FifoDepth`, default 4: number of buffered records; power of two, ≥2.

Ports:
- `clk_i` — input, 1: the single clock.
- `rst_i` — input, 1: reset, asynchronous, active-high.
- `reg_wr_valid_i` — input, 1: the DUT wrote one register for the in-flight instruction this cycle.
- `reg_wr_key_i` — input, `reg_key_t`: key of that write (id plus `reg_key_type_e`).
- `reg_wr_value_i` — input, `freg_t`: value written.
- `retire_valid_i` — input, 1: the in-flight instruction retires this cycle.
- `retire_pc_i` — input, `reg_t`: pc of the retiring instruction.
- `rec_valid_o` — output, 1: the head record is valid.
- `rec_ready_i` — input, 1: the checker accepts the head record.
- `rec_pc_o` — output, `reg_t`: pc of the head record.
- `rec_reg_write_o` — output, `commit_log_reg_item_t [CommitLogEntries]`: register writes of the head record, in arrival order.
- `rec_count_o` — output, `$clog2(CommitLogEntries+1)`: number of valid entries in `rec_reg_write_o`.
- `level_o` — output, `$clog2(FifoDepth+1)`: FIFO occupancy.
- `overflow_o` — output, 1: sticky; an instruction produced more than `CommitLogEntries` writes.
- `drop_o` — output, 1: sticky; a record was discarded because the FIFO was full.

## Operation

Accumulator:
- Holds `acc_cnt` (0..`CommitLogEntries`) and `acc[]`.
- On `reg_wr_valid_i` with `acc_cnt < CommitLogEntries`: `acc[acc_cnt] <= {key, value}`, `acc_cnt++`.
- On `reg_wr_valid_i` with `acc_cnt == CommitLogEntries`: the write is discarded and `overflow_o <= 1`.
- No filtering: x0 writes and repeated keys are all logged, in order.

Retire:
- On `retire_valid_i` the record is built as {`retire_pc_i`, `acc` entries, plus the same-cycle write if one is present and there is room}.
- Unused entry slots are zero. The count includes the same-cycle write.
- `acc_cnt` clears to 0 in the same cycle, so a write arriving together with the retire belongs to the retiring instruction.
- `retire_valid_i` with no writes produces a record with count 0.

FIFO:
- Push on retire when `level < FifoDepth`, or when `level == FifoDepth` and a pop occurs in the same cycle.
- Otherwise the record is discarded, `drop_o <= 1`, and the accumulator is still cleared.
- Pop when `rec_valid_o && rec_ready_i`.
- Push and pop in the same cycle: `level_o` is unchanged.
- Head/tail pointers are `$clog2(FifoDepth)` bits and wrap naturally.
- Ordering is strict FIFO; the head outputs are first-word-fall-through from storage.
- `rec_valid_o = (level != 0)`.
- Outputs are stable while `rec_valid_o && !rec_ready_i`.

Reset:
- `rst_i` asserted at any time discards the accumulator and all queued records.
- Reset values: `rec_valid_o=0`, `rec_pc_o=0`, `rec_reg_write_o=0`, `rec_count_o=0`, `level_o=0`, `overflow_o=0`, `drop_o=0`.
- Sticky flags clear only on reset.

## Timing

- Retire in cycle t with an empty FIFO → `rec_valid_o=1` with that record in cycle t+1.
- Pop in cycle t → next record (or `rec_valid_o=0`) in t+1; one record per cycle is sustainable.
- `overflow_o` rises in the cycle after the first dropped write; `drop_o` rises in the cycle after the discarded retire.
- `level_o` reflects pushes and pops one cycle after they occur.
- No combinational path from `rec_ready_i` to any output. `rec_ready_i` must not depend on `rec_valid_o` falling.

## Test plan

1. Reset:
   - Stimulus: hold `rst_i=1` with random inputs active.
   - Required: `rec_valid_o=0`, `rec_count_o=0`, `level_o=0`, `overflow_o=0`, `drop_o=0`.
2. Single instruction:
   - Stimulus: write {id 5, XREG}=0x1234 at cycle 0; retire pc=0x8000_0000 at cycle 1.
   - Required at cycle 2: `rec_valid_o=1`, pc 0x8000_0000, count 1, entry0 = {5, XREG, 0x1234}, entries 1..15 zero.
3. Same-cycle write and retire:
   - Stimulus: write {0x300, CSR}=0x8 together with retire pc=0x8000_0004; no earlier writes.
   - Required: count 1, entry0 = the CSR write; next instruction's record starts with count 0.
4. Overflow:
   - Stimulus: 17 XREG writes (values 1..17), then retire.
   - Required: count 16, values 1..16 in order; `overflow_o=1` from the cycle after the 17th write.
5. Backpressure and drop:
   - Stimulus: `rec_ready_i=0`; retire pcs 0x0, 0x4, 0x8, 0xC, 0x10.
   - Required: `level_o=4`, `drop_o=1`; with `rec_ready_i=1`, pops return 0x0, 0x4, 0x8, 0xC, then `rec_valid_o=0`.
6. Full with simultaneous pop and push:
   - Stimulus: `level_o=4`, `rec_ready_i=1` and retire in the same cycle.
   - Required: `level_o` stays 4, `drop_o` stays 0, new record appears last.
